// File: rtl/wr_dp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wr_dp_pkg : shared types and header helper for the multi-channel write path
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
package wr_dp_pkg;

    localparam int NBYTES_DEF = 64;
    localparam int HDR_W      = 8;

    typedef enum logic [6:0] {
        CH_TX   = 7'd0,
        CH_CRD  = 7'd1,
        CH_RESP = 7'd2
    } ch_id_e;

    // Flit header: valid marker in the MSB, source channel id below it
    function automatic logic [HDR_W-1:0] mk_hdr(input logic [6:0] ch_id);
        return {1'b1, ch_id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wr_dp_ch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wr_dp_ch_fifo : per-channel synchronous FIFO, registered count, no bypass
// Rev 1.0       : initial release
// ---------------------------------------------------------------------------
module wr_dp_ch_fifo
    import wr_dp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot
    assign full    = (count_q == C_DEPTH);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/wr_datapath_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wr_datapath_mc : NCH channel FIFOs arbitrated into one registered RDI stage
//                  WR_DP_RR_ARB_EN selects round-robin, else fixed priority
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
module wr_datapath_mc
    import wr_dp_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int NBYTES = NBYTES_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic [NCH-1:0]                      ch_valid,
    input  logic [NCH*(NBYTES*8-HDR_W)-1:0]     ch_data,
    output logic [NCH-1:0]                      ch_ready,
    input  logic                                lp_irdy_i,
    input  logic                                pl_trdy,
    output logic [NBYTES*8-1:0]                 lp_data,
    output logic                                lp_valid,
    output logic                                lp_irdy
);

    localparam int DW = NBYTES * 8;
    localparam int PW = DW - HDR_W;

    logic [NCH-1:0] fifo_full;
    logic [NCH-1:0] fifo_empty;
    logic [NCH-1:0] fifo_push;
    logic [NCH-1:0] fifo_pop;
    logic [PW-1:0]  fifo_dout [NCH];

    logic           slot_free;
    logic           gnt_vld;
    logic [6:0]     gnt_id;
    logic           take;
    logic [PW-1:0]  gnt_payload;

    logic           lp_valid_q, lp_valid_d;
    logic [DW-1:0]  lp_data_q, lp_data_d;

    assign ch_ready  = ~fifo_full;
    assign fifo_push = ch_valid & ~fifo_full;
    assign slot_free = ~lp_valid_q | pl_trdy;
    assign take      = slot_free & enable & gnt_vld;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            wr_dp_ch_fifo #(
                .DEPTH (DEPTH),
                .W     (PW)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (fifo_push[i]),
                .pop   (fifo_pop[i]),
                .din   (ch_data[i*PW +: PW]),
                .dout  (fifo_dout[i]),
                .full  (fifo_full[i]),
                .empty (fifo_empty[i])
            );
        end
    endgenerate

`ifdef WR_DP_RR_ARB_EN
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    // Lowest non-empty channel at/after the pointer wins, else wrap to lowest overall
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (!fifo_empty[j]) begin
                gnt_vld = 1'b1;
                gnt_id  = 7'(j);
            end
        end
        for (int j = NCH - 1; j >= 0; j--) begin
            if (!fifo_empty[j] && (j >= int'(rr_ptr_q))) begin
                gnt_id = 7'(j);
            end
        end
    end

    always_comb begin
        int nxt;
        nxt      = 0;
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            nxt = int'(gnt_id) + 1;
            if (nxt >= NCH) begin
                nxt = 0;
            end
            rr_ptr_d = PTR_W'(nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (!fifo_empty[j]) begin
                gnt_vld = 1'b1;
                gnt_id  = 7'(j);
            end
        end
    end
`endif

    always_comb begin
        fifo_pop    = '0;
        gnt_payload = '0;
        for (int j = 0; j < NCH; j++) begin
            if (gnt_id == 7'(j)) begin
                fifo_pop[j] = take;
                gnt_payload = fifo_dout[j];
            end
        end
    end

    // A stalled flit (valid without trdy) holds; an idle free slot clears the bus
    always_comb begin
        lp_valid_d = lp_valid_q;
        lp_data_d  = lp_data_q;
        if (slot_free) begin
            lp_valid_d = take;
            lp_data_d  = take ? {mk_hdr(gnt_id), gnt_payload} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_valid_q <= 1'b0;
            lp_data_q  <= '0;
        end else begin
            lp_valid_q <= lp_valid_d;
            lp_data_q  <= lp_data_d;
        end
    end

    assign lp_valid = lp_valid_q;
    assign lp_data  = lp_data_q;
    assign lp_irdy  = lp_irdy_i | lp_valid_q;

endmodule
`default_nettype wire
